// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle MULT/MULTU/DIV/DIVU unit that owns the HI/LO pair.
// Optional build macro: MULDIV_EARLY_OUT_EN (multiply stops once the remaining
// multiplier bits are all zero; divide is unaffected).
//
// state | meaning
// IDLE  | accepting requests; MTHI/MTLO write HI/LO here
// CALC  | one shift-add (mul) or shift-subtract (div) iteration per cycle
// FIX   | sign correction and HI/LO commit
module muldiv_sequencer #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             op_start,
   input  logic [1:0]       op_sel,
   input  logic             op_uns,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic             mthi_w,
   input  logic             mtlo_w,
   input  logic             mf_req,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             stall
);
   typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;       // mul: product; div: remainder in low half
   logic [2*WIDTH-1:0] mcand_q, mcand_d;   // mul: shifted multiplicand; div: divisor in low half
   logic [WIDTH-1:0]   shr_q, shr_d;       // mul: multiplier, shifts right; div: dividend -> quotient
   logic [WIDTH-1:0]   a_raw_q, a_raw_d;   // dividend as issued, returned in HI on divide-by-zero
   logic               is_div_q, is_div_d;
   logic               neg_q, neg_d;
   logic               neg_rem_q, neg_rem_d;
   logic               dbz_q, dbz_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;

   logic               start_ok;
   logic               a_neg, b_neg;
   logic [WIDTH-1:0]   a_abs, b_abs;
   logic [WIDTH:0]     rem_sh, rem_diff;
   logic [2*WIDTH-1:0] prod_fix;
   logic               calc_done;

   assign start_ok = op_start & ((op_sel == 2'b01) | (op_sel == 2'b10));
   assign a_neg    = ~op_uns & src_a[WIDTH-1];
   assign b_neg    = ~op_uns & src_b[WIDTH-1];
   assign a_abs    = a_neg ? -src_a : src_a;
   assign b_abs    = b_neg ? -src_b : src_b;
   assign rem_sh   = {acc_q[WIDTH-1:0], shr_q[WIDTH-1]};
   assign rem_diff = rem_sh - {1'b0, mcand_q[WIDTH-1:0]};
   assign prod_fix = neg_q ? -acc_q : acc_q;

   // The product accumulator is never shifted, so stopping early needs no realignment.
`ifdef MULDIV_EARLY_OUT_EN
   assign calc_done = (cnt_q == CNT_W'(WIDTH-1)) | (~is_div_q & (shr_q[WIDTH-1:1] == '0));
`else
   assign calc_done = (cnt_q == CNT_W'(WIDTH-1));
`endif

   assign busy  = (state_q != IDLE);
   assign stall = busy & (op_start | mthi_w | mtlo_w | mf_req);
   assign hi    = hi_q;
   assign lo    = lo_q;

   // Next-state, datapath iteration and HI/LO update.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      mcand_d   = mcand_q;
      shr_d     = shr_q;
      a_raw_d   = a_raw_q;
      is_div_d  = is_div_q;
      neg_d     = neg_q;
      neg_rem_d = neg_rem_q;
      dbz_d     = dbz_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      case (state_q)
         IDLE: begin
            if (start_ok) begin
               is_div_d  = op_sel[1];
               neg_d     = a_neg ^ b_neg;
               neg_rem_d = a_neg;
               a_raw_d   = src_a;
               cnt_d     = '0;
               acc_d     = '0;
               if (op_sel[1]) begin
                  mcand_d = {{WIDTH{1'b0}}, b_abs};
                  shr_d   = a_abs;
                  dbz_d   = (src_b == '0);
                  state_d = (src_b == '0) ? FIX : CALC;
               end else begin
                  mcand_d = {{WIDTH{1'b0}}, a_abs};
                  shr_d   = b_abs;
                  dbz_d   = 1'b0;
                  state_d = CALC;
               end
            end else begin
               if (mthi_w) hi_d = src_a;
               if (mtlo_w) lo_d = src_a;
            end
         end
         CALC: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (is_div_q) begin
               if (!rem_diff[WIDTH]) begin
                  acc_d[WIDTH-1:0] = rem_diff[WIDTH-1:0];
                  shr_d            = {shr_q[WIDTH-2:0], 1'b1};
               end else begin
                  acc_d[WIDTH-1:0] = rem_sh[WIDTH-1:0];
                  shr_d            = {shr_q[WIDTH-2:0], 1'b0};
               end
            end else begin
               if (shr_q[0]) acc_d = acc_q + mcand_q;
               mcand_d = {mcand_q[2*WIDTH-2:0], 1'b0};
               shr_d   = {1'b0, shr_q[WIDTH-1:1]};
            end
            if (calc_done) state_d = FIX;
         end
         FIX: begin
            if (!is_div_q) begin
               hi_d = prod_fix[2*WIDTH-1:WIDTH];
               lo_d = prod_fix[WIDTH-1:0];
            end else if (dbz_q) begin
               hi_d = a_raw_q;
               lo_d = '1;
            end else begin
               lo_d = neg_q ? -shr_q : shr_q;
               hi_d = neg_rem_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         acc_q     <= '0;
         mcand_q   <= '0;
         shr_q     <= '0;
         a_raw_q   <= '0;
         is_div_q  <= 1'b0;
         neg_q     <= 1'b0;
         neg_rem_q <= 1'b0;
         dbz_q     <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         mcand_q   <= mcand_d;
         shr_q     <= shr_d;
         a_raw_q   <= a_raw_d;
         is_div_q  <= is_div_d;
         neg_q     <= neg_d;
         neg_rem_q <= neg_rem_d;
         dbz_q     <= dbz_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end
endmodule
